rv32_mem_arbiter: RTL and testbench

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

---
 rtl/rv32_bus_pkg.sv | 33 +++
 rtl/rv32_timeout_counter.sv | 31 +++
 rtl/rv32_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bus_pkg.sv
// Purpose: shared types for the RV32 memory arbiter (FSM states, latched bus request).
// Latency: n/a (types and helpers only).
// Backpressure: n/a; the request struct holds one transaction until the bus completes or aborts it.
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_GRANT_INSTR = 2'd1,
        ST_GRANT_DATA  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic [3:0]  mask;
        logic [31:0] value;
    } bus_req_t;

    localparam bus_req_t BUS_REQ_IDLE = '0;

    function automatic bus_req_t make_req(input logic [31:0] address,
                                          input logic        read,
                                          input logic [3:0]  mask,
                                          input logic [31:0] value);
        bus_req_t r;
        r.address = address;
        r.read    = read;
        r.mask    = mask;
        r.value   = value;
        return r;
    endfunction

endpackage

// File: rtl/rv32_timeout_counter.sv
// Purpose: counts granted bus cycles and flags the last cycle before a transaction must abort.
// Latency: expired is combinational from the count; the count advances one per enabled cycle.
// Backpressure: none; clear has priority and the count saturates at TIMEOUT_CYCLES-1.
// Ports: clk/reset, clear (restart count), enable (a grant is active), expired (count at limit while enabled).
module rv32_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 16'd1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Purpose: arbitrates an instruction port and a data port onto one shared memory bus.
// Latency: 2 cycles minimum request-to-ready (IDLE latch, then one grant cycle); always returns via IDLE.
// Backpressure: requesters hold inputs until their one-cycle ready pulse; bus stalls via bus_ready_in, bounded by timeout.
// Ports: instr_* fetch port, data_* load/store port, bus_* shared bus, fault_out pulses on timeout abort.
module rv32_mem_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic [31:0] bus_address_out,
    output logic        bus_read_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in,
    output logic        fault_out
);

    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_DATA_BURST);

    arb_state_t    state;
    bus_req_t      req_q;
    logic [BW-1:0] burst_count;

    logic        data_req;
    logic        instr_wins;
    logic        data_wins;
    logic        granted;
    logic        tmo_expired;
    logic [31:0] complete_value;

    assign data_req   = data_read_in || (data_write_mask_in != 4'h0);
    // Data normally wins; once the data port has taken MAX_DATA_BURST grants
    // while a fetch waited, the fetch is served next.
    assign instr_wins = instr_read_in && (!data_req || (burst_count == BURST_LIMIT));
    assign data_wins  = data_req && !instr_wins;
    assign granted    = (state != ST_IDLE);

    // A completing bus cycle beats a coinciding timeout; an abort returns zero.
    assign complete_value = bus_ready_in ? bus_read_value_in : 32'h0;

    rv32_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!granted),
        .enable  (granted),
        .expired (tmo_expired)
    );

    // req_q is zero whenever the FSM is idle, so the bus is driven straight from it.
    assign bus_address_out     = req_q.address;
    assign bus_read_out        = req_q.read;
    assign bus_write_mask_out  = req_q.mask;
    assign bus_write_value_out = req_q.value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            req_q                <= BUS_REQ_IDLE;
            burst_count          <= '0;
            instr_read_value_out <= '0;
            data_read_value_out  <= '0;
            instr_ready_out      <= 1'b0;
            data_ready_out       <= 1'b0;
            fault_out            <= 1'b0;
        end else begin
            instr_ready_out <= 1'b0;
            data_ready_out  <= 1'b0;
            fault_out       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_wins) begin
                        req_q       <= make_req(instr_address_in, 1'b1, 4'h0, 32'h0);
                        burst_count <= '0;
                        state       <= ST_GRANT_INSTR;
                    end else if (data_wins) begin
                        req_q       <= make_req(data_address_in, data_read_in,
                                                data_write_mask_in, data_write_value_in);
                        burst_count <= instr_read_in ? burst_count + BW'(1) : '0;
                        state       <= ST_GRANT_DATA;
                    end else if (!instr_read_in) begin
                        burst_count <= '0;
                    end
                end
                ST_GRANT_INSTR, ST_GRANT_DATA: begin
                    if (bus_ready_in || tmo_expired) begin
                        if (state == ST_GRANT_INSTR) begin
                            instr_ready_out      <= 1'b1;
                            instr_read_value_out <= complete_value;
                        end else begin
                            data_ready_out      <= 1'b1;
                            data_read_value_out <= complete_value;
                        end
                        fault_out <= !bus_ready_in;
                        req_q     <= BUS_REQ_IDLE;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    req_q <= BUS_REQ_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Purpose: self-checking bench for rv32_mem_arbiter against a transaction-level model.
// Latency: n/a.
// Backpressure: bench drives bus_ready_in directly.
module tb_rv32_mem_arbiter;

    localparam int TMO  = 8;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address_in;
    logic        instr_read_in;
    logic [31:0] instr_read_value_out;
    logic        instr_ready_out;
    logic [31:0] data_address_in;
    logic        data_read_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic [31:0] data_read_value_out;
    logic        data_ready_out;
    logic [31:0] bus_address_out;
    logic        bus_read_out;
    logic [3:0]  bus_write_mask_out;
    logic [31:0] bus_write_value_out;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;
    logic        fault_out;

    rv32_mem_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_DATA_BURST(MAXB)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_address_in     (instr_address_in),
        .instr_read_in        (instr_read_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_ready_out      (instr_ready_out),
        .data_address_in      (data_address_in),
        .data_read_in         (data_read_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_write_value_in  (data_write_value_in),
        .data_read_value_out  (data_read_value_out),
        .data_ready_out       (data_ready_out),
        .bus_address_out      (bus_address_out),
        .bus_read_out         (bus_read_out),
        .bus_write_mask_out   (bus_write_mask_out),
        .bus_write_value_out  (bus_write_value_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in),
        .fault_out            (fault_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    // owner: 0 = bus free, 1 = fetch in flight, 2 = data access in flight.
    // age: granted cycles already spent waiting on the bus.
    // streak: data grants taken while a fetch was waiting.
    int          owner  = 0;
    int          age    = 0;
    int          streak = 0;
    logic [31:0] m_addr = '0;
    logic        m_rd   = 1'b0;
    logic [3:0]  m_mask = '0;
    logic [31:0] m_val  = '0;
    logic        exp_iready = 1'b0;
    logic        exp_dready = 1'b0;
    logic        exp_fault  = 1'b0;
    logic [31:0] exp_ival   = '0;
    logic [31:0] exp_dval   = '0;

    logic m_dreq;
    logic m_take_instr;
    assign m_dreq       = data_read_in || (data_write_mask_in != 4'h0);
    assign m_take_instr = instr_read_in && (!m_dreq || (streak == MAXB));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= 0; age <= 0; streak <= 0;
            m_addr <= '0; m_rd <= 1'b0; m_mask <= '0; m_val <= '0;
            exp_iready <= 1'b0; exp_dready <= 1'b0; exp_fault <= 1'b0;
            exp_ival <= '0; exp_dval <= '0;
        end else begin
            exp_iready <= 1'b0;
            exp_dready <= 1'b0;
            exp_fault  <= 1'b0;
            if (owner == 0) begin
                age <= 0;
                if (m_take_instr) begin
                    owner <= 1; m_addr <= instr_address_in; m_rd <= 1'b1;
                    m_mask <= 4'h0; m_val <= 32'h0; streak <= 0;
                end else if (m_dreq) begin
                    owner <= 2; m_addr <= data_address_in; m_rd <= data_read_in;
                    m_mask <= data_write_mask_in; m_val <= data_write_value_in;
                    streak <= instr_read_in ? streak + 1 : 0;
                end else begin
                    streak <= 0;
                end
            end else if (bus_ready_in || (age + 1 == TMO)) begin
                if (owner == 1) begin
                    exp_iready <= 1'b1;
                    exp_ival   <= bus_ready_in ? bus_read_value_in : 32'h0;
                end else begin
                    exp_dready <= 1'b1;
                    exp_dval   <= bus_ready_in ? bus_read_value_in : 32'h0;
                end
                exp_fault <= !bus_ready_in;
                owner <= 0;
            end else begin
                age <= age + 1;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic  rec = 1'b0;
    string seq = "";

    always @(negedge clk) begin
        chk("bus_address", bus_address_out,     (owner != 0) ? m_addr : 32'h0);
        chk("bus_read",    bus_read_out,        (owner != 0) ? m_rd   : 1'b0);
        chk("bus_mask",    bus_write_mask_out,  (owner != 0) ? m_mask : 4'h0);
        chk("bus_value",   bus_write_value_out, (owner != 0) ? m_val  : 32'h0);
        chk("instr_ready", instr_ready_out,     exp_iready);
        chk("data_ready",  data_ready_out,      exp_dready);
        chk("fault",       fault_out,           exp_fault);
        chk("instr_value", instr_read_value_out, exp_ival);
        chk("data_value",  data_read_value_out,  exp_dval);
        if (rec && instr_ready_out) seq <= {seq, "I"};
        if (rec && data_ready_out)  seq <= {seq, "D"};
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        logic f_seen;
        logic [31:0] v_seen;

        reset = 1'b1;
        instr_address_in = '0; instr_read_in = 1'b0;
        data_address_in = '0; data_read_in = 1'b0;
        data_write_mask_in = '0; data_write_value_in = '0;
        bus_read_value_in = '0; bus_ready_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_bus_address", bus_address_out, 32'h0);
        chk("reset_ready",       {instr_ready_out, data_ready_out, fault_out}, 32'h0);
        reset = 1'b0;

        // single fetch
        tick();
        instr_read_in = 1'b1; instr_address_in = 32'h100;
        tick();
        chk("fetch_bus_address", bus_address_out, 32'h100);
        chk("fetch_bus_read",    bus_read_out, 1'b1);
        bus_ready_in = 1'b1; bus_read_value_in = 32'hDEADBEEF;
        tick();
        chk("fetch_ready", instr_ready_out, 1'b1);
        chk("fetch_value", instr_read_value_out, 32'hDEADBEEF);
        instr_read_in = 1'b0; bus_ready_in = 1'b0; bus_read_value_in = '0;
        tick();
        chk("fetch_ready_once", instr_ready_out, 1'b0);

        // bus_ready_in while idle is ignored
        bus_ready_in = 1'b1; bus_read_value_in = 32'hBAD0BAD0;
        repeat (2) tick();
        chk("idle_ready_ignored", {instr_ready_out, data_ready_out}, 32'h0);
        chk("idle_value_held",    instr_read_value_out, 32'hDEADBEEF);
        bus_ready_in = 1'b0; bus_read_value_in = '0;
        tick();

        // simultaneous fetch and write: data first, then fetch
        instr_read_in = 1'b1; instr_address_in = 32'h0;
        data_address_in = 32'h200; data_write_mask_in = 4'hF; data_write_value_in = 32'h12345678;
        tick();
        chk("sim_data_addr",  bus_address_out, 32'h200);
        chk("sim_data_mask",  bus_write_mask_out, 4'hF);
        chk("sim_data_value", bus_write_value_out, 32'h12345678);
        bus_ready_in = 1'b1; bus_read_value_in = 32'hCAFE0001;
        tick();
        chk("sim_data_ready", data_ready_out, 1'b1);
        chk("sim_write_value", data_read_value_out, 32'hCAFE0001);
        data_write_mask_in = 4'h0; bus_ready_in = 1'b0;
        tick();
        chk("sim_instr_read", bus_read_out, 1'b1);
        chk("sim_instr_mask", bus_write_mask_out, 4'h0);
        bus_ready_in = 1'b1; bus_read_value_in = 32'h11112222;
        tick();
        chk("sim_instr_ready", instr_ready_out, 1'b1);
        chk("sim_instr_value", instr_read_value_out, 32'h11112222);
        instr_read_in = 1'b0; bus_ready_in = 1'b0;
        tick();

        // fairness: both ports held, bus always ready
        instr_read_in = 1'b1; instr_address_in = 32'h40;
        data_read_in = 1'b1; data_address_in = 32'h80;
        bus_ready_in = 1'b1; bus_read_value_in = 32'h0000F00D;
        rec = 1'b1;
        repeat (30) tick();
        instr_read_in = 1'b0; data_read_in = 1'b0; bus_ready_in = 1'b0;
        tick();
        rec = 1'b0;
        checks++;
        if (seq != "DDDDIDDDDIDDDDI") begin
            failures++;
            $display("FAIL fairness_sequence: got %s expected DDDDIDDDDIDDDDI", seq);
        end

        // timeout: data read, bus never ready
        data_read_in = 1'b1; data_address_in = 32'h300;
        tick();
        chk("tmo_granted", bus_address_out, 32'h300);
        n = 0; f_seen = 1'b0; v_seen = 32'hFFFFFFFF;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (data_ready_out) begin
                n = i; f_seen = fault_out; v_seen = data_read_value_out;
                break;
            end
        end
        data_read_in = 1'b0;
        chk("tmo_latency", n, 8);
        chk("tmo_fault",   f_seen, 1'b1);
        chk("tmo_value",   v_seen, 32'h0);
        tick();

        // bus ready on the last allowed cycle wins over the timeout
        data_read_in = 1'b1; data_address_in = 32'h304;
        tick();
        repeat (7) tick();
        chk("coin_still_waiting", data_ready_out, 1'b0);
        bus_ready_in = 1'b1; bus_read_value_in = 32'hA5A5A5A5;
        tick();
        chk("coin_ready", data_ready_out, 1'b1);
        chk("coin_fault", fault_out, 1'b0);
        chk("coin_value", data_read_value_out, 32'hA5A5A5A5);
        data_read_in = 1'b0; bus_ready_in = 1'b0;
        tick();

        // reset in the middle of a data grant
        data_read_in = 1'b1; data_address_in = 32'h400;
        data_write_mask_in = 4'h3; data_write_value_in = 32'h55;
        tick();
        chk("rst_mid_granted", bus_write_mask_out, 4'h3);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_bus_address", bus_address_out, 32'h0);
        chk("rst_mid_bus_ctrl",    {bus_read_out, bus_write_mask_out}, 32'h0);
        chk("rst_mid_bus_value",   bus_write_value_out, 32'h0);
        chk("rst_mid_pulses",      {instr_ready_out, data_ready_out, fault_out}, 32'h0);
        chk("rst_mid_values",      instr_read_value_out | data_read_value_out, 32'h0);
        data_read_in = 1'b0; data_write_mask_in = 4'h0; data_write_value_in = '0;
        tick();
        reset = 1'b0;
        bus_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_pulse", {data_ready_out, fault_out}, 32'h0);
        end
        bus_ready_in = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
